// File: rtl/token_rate_divider.sv
// Multi-lane serial token decimator: each lane passes one of every div_cur tokens,
// either the first or the last token of each group, with zero latency.
module token_rate_divider #(
  parameter int CHANNELS = 4,
  parameter int MAX_DIV  = 16,
  parameter int DIV_W    = $clog2(MAX_DIV + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_load,
  input  logic [DIV_W-1:0]    div_in,
  input  logic                mode_in,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] a,
  output logic [CHANNELS-1:0] b,
  output logic [DIV_W-1:0]    div_cur,
  output logic                mode_cur
);

  logic [DIV_W-1:0] div_r;
  logic             mode_r;
  logic [DIV_W-1:0] cnt     [CHANNELS];
  logic [DIV_W-1:0] cnt_nxt [CHANNELS];
  logic [DIV_W-1:0] div_san;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] d_last;
  logic             m;

  always_comb begin
    if (div_in <= DIV_W'(1))
      div_san = DIV_W'(1);
    else if (div_in > DIV_W'(MAX_DIV))
      div_san = DIV_W'(MAX_DIV);
    else
      div_san = div_in;
  end

  // A load cycle already runs under the new configuration from a cleared count.
  assign d      = cfg_load ? div_san : div_r;
  assign m      = cfg_load ? mode_in : mode_r;
  assign d_last = d - DIV_W'(1);

  always_comb begin
    b = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic [DIV_W-1:0] c;
      logic             last;
      logic             hit;
      logic             tok;
      c    = cfg_load ? '0 : cnt[i];
      last = (c == d_last);
      hit  = m ? (c == '0) : last;
      tok  = a[i] & en[i];
      b[i] = tok & ~rst & hit;
      if (tok)
        cnt_nxt[i] = last ? '0 : c + DIV_W'(1);
      else
        cnt_nxt[i] = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_r  <= DIV_W'(2);
      mode_r <= 1'b0;
      for (int i = 0; i < CHANNELS; i++)
        cnt[i] <= '0;
    end else begin
      if (cfg_load) begin
        div_r  <= div_san;
        mode_r <= mode_in;
      end
      for (int i = 0; i < CHANNELS; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end

  assign div_cur  = div_r;
  assign mode_cur = mode_r;

endmodule
